// File: rtl/vga_capture_if.sv
// Frame-buffer write port of the VGA capture block.
// Valid/ready handshake carrying a pixel index and its 24-bit colour.
interface vga_capture_if #(
  parameter int ADDR_W = 19
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: measures line/frame timing against the expected mode
// and grabs one full frame into a small write FIFO on request.
module vga_capture #(
  parameter int H_TOTAL    = 1040,
  parameter int H_DISP     = 800,
  parameter int V_TOTAL    = 666,
  parameter int V_DISP     = 600,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic        cap_start,
  vga_capture_if.master wr,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        cap_err,
  output logic        fifo_ovf,
  output logic        locked,
  output logic [10:0] meas_h_total,
  output logic [10:0] meas_h_active,
  output logic [9:0]  meas_v_total,
  output logic [9:0]  meas_v_active
);

  localparam int PIX = H_DISP * V_DISP;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = ADDR_W + 1;
  localparam int EW  = ADDR_W + 24;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t         state;
  logic [23:0]    pix_q;
  logic           hs_q;
  logic           vs_q;
  logic           blank_q;
  logic           hs_p;
  logic           vs_p;
  logic           hs_fall;
  logic           vs_fall;

  logic [10:0]    h_cnt;
  logic [10:0]    a_cnt;
  logic           line_act;
  logic           h_seen;
  logic [9:0]     v_cnt;
  logic [9:0]     va_cnt;
  logic           v_seen;
  logic           match_prev;
  logic           frame_ok;

  logic [CW-1:0]  pix_cnt;
  logic [CW-1:0]  pix_nxt;
  logic           push;
  logic           pop;
  logic           full;
  logic           accept;
  logic           drop;
  logic [PW:0]    wp;
  logic [PW:0]    rp;
  logic [PW:0]    level;
  logic [EW-1:0]  mem [FIFO_DEPTH];

  assign hs_fall = hs_p & ~hs_q;
  assign vs_fall = vs_p & ~vs_q;

  // Register the pixel bus once and keep the previous sync levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
    end else begin
      pix_q   <= {vga_r, vga_g, vga_b};
      hs_q    <= vga_hs;
      vs_q    <= vga_vs;
      blank_q <= vga_blank_n;
      hs_p    <= hs_q;
      vs_p    <= vs_q;
    end
  end

  // Per-line measurement; blank lines carry no active-width figure,
  // so meas_h_active reflects the last line that had pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt         <= '0;
      a_cnt         <= '0;
      line_act      <= 1'b0;
      h_seen        <= 1'b0;
      meas_h_total  <= '0;
      meas_h_active <= '0;
    end else if (hs_fall) begin
      h_cnt    <= 11'd1;
      a_cnt    <= 11'(blank_q);
      line_act <= blank_q;
      h_seen   <= 1'b1;
      if (h_seen) begin
        meas_h_total <= h_cnt;
        if (line_act) meas_h_active <= a_cnt;
      end
    end else begin
      h_cnt    <= h_cnt + 11'd1;
      a_cnt    <= a_cnt + 11'(blank_q);
      line_act <= line_act | blank_q;
    end
  end

  assign frame_ok = (meas_h_total  == 11'(H_TOTAL)) &&
                    (meas_h_active == 11'(H_DISP))  &&
                    (v_cnt         == 10'(V_TOTAL)) &&
                    (va_cnt        == 10'(V_DISP));

  // Per-frame measurement and lock tracking over two good frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_cnt         <= '0;
      va_cnt        <= '0;
      v_seen        <= 1'b0;
      match_prev    <= 1'b0;
      locked        <= 1'b0;
      meas_v_total  <= '0;
      meas_v_active <= '0;
    end else if (vs_fall) begin
      v_cnt  <= hs_fall ? 10'd1 : 10'd0;
      va_cnt <= (hs_fall && line_act) ? 10'd1 : 10'd0;
      v_seen <= 1'b1;
      if (v_seen) begin
        meas_v_total  <= v_cnt;
        meas_v_active <= va_cnt;
        locked        <= frame_ok & match_prev;
        match_prev    <= frame_ok;
      end
    end else if (hs_fall) begin
      v_cnt <= v_cnt + 10'd1;
      if (line_act) va_cnt <= va_cnt + 10'd1;
    end
  end

  assign level   = wp - rp;
  assign full    = (level == (PW+1)'(FIFO_DEPTH));
  assign push    = (state == CAPTURE) & blank_q;
  assign pop     = wr.wr_valid & wr.wr_ready;
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign pix_nxt = pix_cnt + CW'(push);

  // Capture sequencer with sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cap_busy <= 1'b0;
      cap_done <= 1'b0;
      cap_err  <= 1'b0;
      fifo_ovf <= 1'b0;
      pix_cnt  <= '0;
    end else begin
      cap_done <= 1'b0;
      pix_cnt  <= pix_nxt;
      if (drop) begin
        fifo_ovf <= 1'b1;
        cap_err  <= 1'b1;
      end
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (cap_start) begin
            state    <= ARMED;
            cap_busy <= 1'b1;
            cap_err  <= 1'b0;
            fifo_ovf <= 1'b0;
          end
        end
        ARMED: begin
          if (vs_fall) begin
            state   <= CAPTURE;
            pix_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (vs_fall) begin
            state    <= DONE;
            cap_busy <= 1'b0;
            cap_done <= 1'b1;
            if (pix_nxt != CW'(PIX)) cap_err <= 1'b1;
          end
        end
      endcase
    end
  end

  // Write FIFO; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wp[PW-1:0]] <= {pix_cnt[ADDR_W-1:0], pix_q};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

  assign wr.wr_valid = (wp != rp);
  assign wr.wr_addr  = mem[rp[PW-1:0]][EW-1:24];
  assign wr.wr_data  = mem[rp[PW-1:0]][23:0];

endmodule
